// File: rtl/axis_chk_pkg.sv
`default_nettype none
// ============================================================================
// Module   : axis_chk_pkg
// Brief    : Shared constants and helpers for the AXI4-Stream checker slice.
// Revision : 1.0 - initial release
// ============================================================================
package axis_chk_pkg;

  // Default widths and limits
  localparam int DATA_W_DEF        = 64;
  localparam int CNT_W_DEF         = 32;
  localparam int MAX_PKT_BEATS_DEF = 256;

  // Sticky error flag layout
  localparam int ERR_W          = 4;
  localparam int ERR_VALID_DROP = 0;
  localparam int ERR_PAYLOAD    = 1;
  localparam int ERR_SEQ        = 2;
  localparam int ERR_OVERLEN    = 3;

  // Expected sequence byte after a beat: restarts at 0 on packet end, wraps at 255
  function automatic logic [7:0] seq_next(input logic [7:0] cur, input logic last);
    return last ? 8'd0 : cur + 8'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/axis_skid_buffer.sv
`default_nettype none
// ============================================================================
// Module   : axis_skid_buffer
// Brief    : Two-entry (output + skid register) full-throughput stream buffer
//            with a registered upstream ready and a reset-release flop.
// Revision : 1.0 - initial release
// ============================================================================
module axis_skid_buffer #(
  parameter int WIDTH = 65
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready
);

  logic             r_rel;
  logic             r_ready;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_skid_data;
  logic             r_skid_valid;

  logic             w_up_hs;
  logic             w_out_load;
  logic             w_out_valid_nxt;
  logic             w_skid_valid_nxt;

  assign w_up_hs    = s_valid & r_ready;
  // Output register may take a new beat when empty or draining this cycle
  assign w_out_load = ~r_out_valid | m_ready;

  // Occupancy next-state: skid drains first, otherwise incoming beat goes to
  // the output register, or parks in the skid if the output is stalled
  always_comb begin
    w_out_valid_nxt  = r_out_valid;
    w_skid_valid_nxt = r_skid_valid;
    if (w_out_load) begin
      if (r_skid_valid) begin
        w_out_valid_nxt  = 1'b1;
        w_skid_valid_nxt = 1'b0;
      end else begin
        w_out_valid_nxt  = w_up_hs;
      end
    end else if (w_up_hs) begin
      w_skid_valid_nxt = 1'b1;
    end
  end

  // Datapath registers; ready is held low for one cycle after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rel        <= 1'b0;
      r_ready      <= 1'b0;
      r_out_data   <= '0;
      r_out_valid  <= 1'b0;
      r_skid_data  <= '0;
      r_skid_valid <= 1'b0;
    end else begin
      r_rel        <= 1'b1;
      r_ready      <= r_rel & ~w_skid_valid_nxt;
      r_out_valid  <= w_out_valid_nxt;
      r_skid_valid <= w_skid_valid_nxt;
      if (w_out_load && r_skid_valid) begin
        r_out_data <= r_skid_data;
      end else if (w_out_load && w_up_hs) begin
        r_out_data <= s_data;
      end
      if (!w_out_load && w_up_hs) begin
        r_skid_data <= s_data;
      end
    end
  end

  assign s_ready = r_ready;
  assign m_data  = r_out_data;
  assign m_valid = r_out_valid;

endmodule
`default_nettype wire

// File: rtl/axis_stream_checker.sv
`default_nettype none
// ============================================================================
// Module   : axis_stream_checker
// Brief    : AXI4-Stream pass-through monitor: forwards beats through a skid
//            buffer, checks upstream protocol and per-packet sequence bytes,
//            and keeps saturating beat/packet counters and sticky errors.
// Revision : 1.0 - initial release
// ============================================================================
module axis_stream_checker
  import axis_chk_pkg::*;
#(
  parameter int DATA_W        = DATA_W_DEF,
  parameter int CNT_W         = CNT_W_DEF,
  parameter int SEQ_CHECK     = 1,
  parameter int MAX_PKT_BEATS = MAX_PKT_BEATS_DEF
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  input  logic              s_axis_tlast,
  output logic              s_axis_tready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  output logic              m_axis_tlast,
  input  logic              m_axis_tready,
  input  logic              clear,
  output logic [CNT_W-1:0]  beat_cnt,
  output logic [CNT_W-1:0]  pkt_cnt,
  output logic [ERR_W-1:0]  err_flags,
  output logic              err_any
);

  localparam int PB_W = $clog2(MAX_PKT_BEATS + 1);

  logic              r_prev_valid;
  logic              r_prev_ready;
  logic [DATA_W-1:0] r_prev_data;
  logic              r_prev_last;
  logic [7:0]        r_seq_exp;
  logic [PB_W-1:0]   r_pkt_beats;
  logic [CNT_W-1:0]  r_beat_cnt;
  logic [CNT_W-1:0]  r_pkt_cnt;
  logic [ERR_W-1:0]  r_err;

  logic              w_up_hs;
  logic              w_stall;
  logic              w_seq_err;
  logic [ERR_W-1:0]  w_det;

  axis_skid_buffer #(
    .WIDTH (DATA_W + 1)
  ) u_skid (
    .clk     (aclk),
    .rst_n   (aresetn),
    .s_data  ({s_axis_tlast, s_axis_tdata}),
    .s_valid (s_axis_tvalid),
    .s_ready (s_axis_tready),
    .m_data  ({m_axis_tlast, m_axis_tdata}),
    .m_valid (m_axis_tvalid),
    .m_ready (m_axis_tready)
  );

  assign w_up_hs = s_axis_tvalid & s_axis_tready;
  assign w_stall = r_prev_valid & ~r_prev_ready;

  if (SEQ_CHECK != 0) begin : g_seq_on
    assign w_seq_err = w_up_hs & (s_axis_tdata[DATA_W-1 -: 8] != r_seq_exp);
  end else begin : g_seq_off
    assign w_seq_err = 1'b0;
  end

  // Per-cycle violation detection against last cycle's upstream snapshot
  always_comb begin
    w_det                 = '0;
    w_det[ERR_VALID_DROP] = w_stall & ~s_axis_tvalid;
    w_det[ERR_PAYLOAD]    = w_stall & s_axis_tvalid &
                            ((s_axis_tdata != r_prev_data) | (s_axis_tlast != r_prev_last));
    w_det[ERR_SEQ]        = w_seq_err;
    w_det[ERR_OVERLEN]    = w_up_hs & (r_pkt_beats == PB_W'(MAX_PKT_BEATS));
  end

  // Upstream snapshot used to recognise a stalled beat next cycle
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_prev_valid <= 1'b0;
      r_prev_ready <= 1'b0;
      r_prev_data  <= '0;
      r_prev_last  <= 1'b0;
    end else begin
      r_prev_valid <= s_axis_tvalid;
      r_prev_ready <= s_axis_tready;
      r_prev_data  <= s_axis_tdata;
      r_prev_last  <= s_axis_tlast;
    end
  end

  // Sequence tracker and in-packet beat count (saturates at the limit);
  // deliberately untouched by clear
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_seq_exp   <= 8'd0;
      r_pkt_beats <= '0;
    end else if (w_up_hs) begin
      r_seq_exp <= seq_next(r_seq_exp, s_axis_tlast);
      if (s_axis_tlast) begin
        r_pkt_beats <= '0;
      end else if (r_pkt_beats != PB_W'(MAX_PKT_BEATS)) begin
        r_pkt_beats <= r_pkt_beats + PB_W'(1);
      end
    end
  end

  // Saturating counters and sticky errors; clear overrides same-cycle events
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_beat_cnt <= '0;
      r_pkt_cnt  <= '0;
      r_err      <= '0;
    end else if (clear) begin
      r_beat_cnt <= '0;
      r_pkt_cnt  <= '0;
      r_err      <= '0;
    end else begin
      r_err <= r_err | w_det;
      if (w_up_hs && !(&r_beat_cnt)) begin
        r_beat_cnt <= r_beat_cnt + CNT_W'(1);
      end
      if (w_up_hs && s_axis_tlast && !(&r_pkt_cnt)) begin
        r_pkt_cnt <= r_pkt_cnt + CNT_W'(1);
      end
    end
  end

  assign beat_cnt  = r_beat_cnt;
  assign pkt_cnt   = r_pkt_cnt;
  assign err_flags = r_err;
  assign err_any   = |r_err;

endmodule
`default_nettype wire

// File: tb/tb_axis_stream_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_axis_stream_checker
// Brief    : Scoreboard bench for axis_stream_checker: driver pushes accepted
//            beats, monitor pops and compares on every downstream handshake
//            and tracks buffer occupancy to check ready/valid behaviour.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axis_stream_checker;

  logic        aclk;
  logic        aresetn;
  logic [63:0] s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tlast;
  logic        s_axis_tready;
  logic [63:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tlast;
  logic        m_axis_tready;
  logic        clear;
  logic [31:0] beat_cnt;
  logic [31:0] pkt_cnt;
  logic [3:0]  err_flags;
  logic        err_any;

  logic        m_rdy_req;
  logic        osc_rdy;
  logic        osc_en;
  logic        model_en;
  int          osc_cnt;
  int          occ;
  int          n_checks;
  int          n_fail;
  logic [64:0] sb_q[$];

  axis_stream_checker #(
    .DATA_W        (64),
    .CNT_W         (32),
    .SEQ_CHECK     (1),
    .MAX_PKT_BEATS (256)
  ) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tready (m_axis_tready),
    .clear         (clear),
    .beat_cnt      (beat_cnt),
    .pkt_cnt       (pkt_cnt),
    .err_flags     (err_flags),
    .err_any       (err_any)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  assign m_axis_tready = osc_en ? osc_rdy : m_rdy_req;

  // Downstream ready pattern: 6 cycles high, 2 cycles low
  initial begin
    osc_rdy = 1'b1;
    osc_cnt = 0;
    forever begin
      @(posedge aclk);
      #1;
      osc_rdy = (osc_cnt < 6);
      osc_cnt = (osc_cnt + 1) % 8;
    end
  end

  task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: occupancy model plus scoreboard pop on each downstream handshake
  always @(negedge aclk) begin
    if (!aresetn) begin
      occ = 0;
    end else begin
      if (model_en) begin
        check("ready_vs_skid", 65'(s_axis_tready), 65'(occ != 2));
        check("valid_vs_occ", 65'(m_axis_tvalid), 65'(occ != 0));
      end
      if (m_axis_tvalid && m_axis_tready) begin
        if (sb_q.size() == 0) begin
          check("unexpected_beat", {m_axis_tlast, m_axis_tdata}, 65'h1_dead_beef_dead_beef);
        end else begin
          check("out_beat", {m_axis_tlast, m_axis_tdata}, sb_q.pop_front());
        end
      end
      occ = occ + ((s_axis_tvalid && s_axis_tready) ? 1 : 0)
                - ((m_axis_tvalid && m_axis_tready) ? 1 : 0);
    end
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic send(input logic [63:0] d, input logic l);
    int  n;
    bit  done;
    n    = 0;
    done = 0;
    s_axis_tdata  = d;
    s_axis_tlast  = l;
    s_axis_tvalid = 1'b1;
    while (!done) begin
      @(negedge aclk);
      if (s_axis_tready) begin
        sb_q.push_back({l, d});
        done = 1;
      end else if (++n > 200) begin
        check("send_timeout", 65'(0), 65'(1));
        done = 1;
      end
      tick();
    end
    s_axis_tvalid = 1'b0;
  endtask

  task automatic send_pkt(input int bad_idx, input logic [7:0] bad_val);
    logic [63:0] d;
    for (int n = 0; n < 8; n++) begin
      d = 64'(n) << 56;
      if (n == bad_idx) d = {bad_val, 56'h0};
      send(d, n == 7);
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((sb_q.size() != 0) && (n < 200)) begin
      @(negedge aclk);
      n++;
    end
    check("drain_timeout", 65'(sb_q.size()), 65'(0));
    tick();
  endtask

  task automatic check_status(input string tag, input int bc, input int pc, input logic [3:0] ef);
    @(negedge aclk);
    check({tag, "_beat_cnt"}, 65'(beat_cnt), 65'(bc));
    check({tag, "_pkt_cnt"}, 65'(pkt_cnt), 65'(pc));
    check({tag, "_err_flags"}, 65'(err_flags), 65'(ef));
    check({tag, "_err_any"}, 65'(err_any), 65'(ef != 4'd0));
    tick();
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check_status("clear", 0, 0, 4'b0000);
  endtask

  task automatic release_reset();
    aresetn = 1'b1;
    @(negedge aclk);
    check("rel_no_edge_ready", 65'(s_axis_tready), 65'(0));
    @(negedge aclk);
    check("rel_edge1_ready", 65'(s_axis_tready), 65'(0));
    @(negedge aclk);
    check("rel_edge2_ready", 65'(s_axis_tready), 65'(1));
    model_en = 1'b1;
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] d;
    n_checks      = 0;
    n_fail        = 0;
    occ           = 0;
    aresetn       = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    clear         = 1'b0;
    m_rdy_req     = 1'b1;
    osc_en        = 1'b0;
    model_en      = 1'b0;

    // Reset values
    repeat (3) tick();
    check("rst_s_tready", 65'(s_axis_tready), 65'(0));
    check("rst_m_tvalid", 65'(m_axis_tvalid), 65'(0));
    check("rst_m_tdata", 65'(m_axis_tdata), 65'(0));
    check_status("rst", 0, 0, 4'b0000);
    release_reset();

    // Clean packet, downstream always ready
    send_pkt(-1, 8'h00);
    wait_drain();
    check_status("pkt_basic", 8, 1, 4'b0000);

    // Same packet with downstream backpressure
    osc_en = 1'b1;
    send_pkt(-1, 8'h00);
    wait_drain();
    osc_en = 1'b0;
    check_status("pkt_osc", 16, 2, 4'b0000);

    // Valid dropped while stalled
    m_rdy_req = 1'b0;
    send(64'h0000_0000_0000_0000, 1'b0);
    send(64'h0100_0000_0000_0000, 1'b1);
    s_axis_tdata  = 64'h0000_0000_0000_00AA;
    s_axis_tlast  = 1'b0;
    s_axis_tvalid = 1'b1;
    repeat (2) tick();
    s_axis_tvalid = 1'b0;
    repeat (2) tick();
    check_status("valid_drop", 18, 3, 4'b0001);
    m_rdy_req = 1'b1;
    wait_drain();
    pulse_clear();

    // Payload changed while stalled
    m_rdy_req = 1'b0;
    send(64'h0000_0000_0000_0000, 1'b0);
    send(64'h0100_0000_0000_0000, 1'b1);
    s_axis_tdata  = 64'h0000_0000_0000_0001;
    s_axis_tlast  = 1'b0;
    s_axis_tvalid = 1'b1;
    tick();
    s_axis_tdata  = 64'h0000_0000_0000_0002;
    tick();
    m_rdy_req = 1'b1;
    send(64'h0000_0000_0000_0002, 1'b1);
    wait_drain();
    check_status("payload_change", 3, 2, 4'b0010);
    pulse_clear();

    // Sequence error on beat 1; data still forwarded
    send_pkt(1, 8'h05);
    wait_drain();
    check_status("seq_err", 8, 1, 4'b0100);
    pulse_clear();
    send_pkt(-1, 8'h00);
    wait_drain();
    check_status("seq_recover", 8, 1, 4'b0000);
    pulse_clear();

    // Overlength: 300 beats, no tlast
    for (int n = 0; n < 300; n++) begin
      d = 64'(n % 256) << 56;
      send(d, 1'b0);
      if (n == 255) begin
        tick();
        check_status("ovl_at_256", 256, 0, 4'b0000);
      end
      if (n == 256) begin
        tick();
        check_status("ovl_at_257", 257, 0, 4'b1000);
      end
    end
    wait_drain();
    check_status("ovl_end", 300, 0, 4'b1000);
    pulse_clear();

    // Reset mid-packet with beats in flight (sequence continues at 44)
    m_rdy_req = 1'b0;
    send(64'h2C00_0000_0000_0000, 1'b0);
    send(64'h2D00_0000_0000_0000, 1'b0);
    aresetn  = 1'b0;
    model_en = 1'b0;
    sb_q.delete();
    #1;
    check("midrst_m_tvalid", 65'(m_axis_tvalid), 65'(0));
    check("midrst_s_tready", 65'(s_axis_tready), 65'(0));
    check("midrst_beat_cnt", 65'(beat_cnt), 65'(0));
    repeat (2) tick();
    m_rdy_req = 1'b1;
    release_reset();
    send_pkt(-1, 8'h00);
    wait_drain();
    check_status("post_reset_pkt", 8, 1, 4'b0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/axis_stream_checker.md
Name: axis_stream_checker

Overview:
- 64-bit AXI4-Stream pass-through monitor placed between an upstream stream master and a downstream stream slave inside the `chip` simulation top.
- Forwards every beat unchanged with full throughput through a skid buffer.
- Checks the upstream side for protocol violations and for a per-packet beat-sequence pattern.
- Exposes beat/packet counters and sticky error flags.

Parameters:
- DATA_W, 64, stream data width in bits; multiple of 8; sequence byte is the top byte.
- CNT_W, 32, width of the beat and packet counters.
- SEQ_CHECK, 1, 1 enables the sequence check (err bit 2); 0 forces that bit to 0.
- MAX_PKT_BEATS, 256, beats per packet above which err bit 3 is raised.

Ports:
- aclk  in  1  clock; all logic is rising-edge.
- aresetn  in  1  asynchronous, active-low reset.
- s_axis_tdata  in  DATA_W  upstream data.
- s_axis_tvalid  in  1  upstream valid.
- s_axis_tlast  in  1  upstream end of packet.
- s_axis_tready  out  1  upstream ready.
- m_axis_tdata  out  DATA_W  downstream data.
- m_axis_tvalid  out  1  downstream valid.
- m_axis_tlast  out  1  downstream end of packet.
- m_axis_tready  in  1  downstream ready.
- clear  in  1  synchronous pulse; zeroes counters and sticky errors.
- beat_cnt  out  CNT_W  accepted upstream beats; saturating.
- pkt_cnt  out  CNT_W  accepted beats with tlast; saturating.
- err_flags  out  4  sticky error bits: [0] valid drop, [1] payload change, [2] sequence, [3] overlength.
- err_any  out  1  OR of err_flags.

Behaviour:
- Reset values: all outputs 0. While aresetn is low: s_axis_tready=0, m_axis_tvalid=0, skid empty.
- Reset release: s_axis_tready rises on the second rising edge after aresetn goes high (release flop), so no beat is accepted in the release cycle.
- Handshakes:
  - Upstream handshake: s_axis_tvalid & s_axis_tready.
  - Downstream handshake: m_axis_tvalid & m_axis_tready.
- Datapath: two-entry skid buffer made of an output register plus a skid register.
  - Latency: 1 cycle from upstream handshake to m_axis_tvalid.
  - Throughput: sustained 1 beat/cycle when m_axis_tready=1.
  - s_axis_tready is registered: it is 1 whenever the skid register is empty and the block is out of reset.
  - A beat accepted while the output register is occupied and not draining goes to the skid register; s_axis_tready drops the next cycle.
  - When the output drains, the skid contents move to the output register and s_axis_tready rises.
  - m_axis payload and tvalid hold stable while m_axis_tready=0.
  - Beats are never dropped, duplicated or reordered; tdata and tlast pass bit-exact.
- Check state: the previous-cycle s_axis_tvalid, s_axis_tready, tdata and tlast are registered, and a stall is defined as prev tvalid=1 with prev tready=0.
- err bit 0 (valid drop): stall and now tvalid=0.
- err bit 1 (payload change): stall, tvalid=1, and tdata or tlast differs from the registered values.
- err bit 2 (sequence): on each upstream handshake, tdata[DATA_W-1:DATA_W-8] must equal seq_exp.
  - seq_exp is 8 bits, 0 after reset.
  - After a handshake: seq_exp <= 0 if tlast, else seq_exp+1 (wraps at 255).
  - The flag is raised on mismatch; seq_exp still updates from the beat's own tlast.
- err bit 3 (overlength): in-packet beat count exceeds MAX_PKT_BEATS; the count resets on the tlast handshake.
- Error bits are set the cycle after detection and stay set until clear or reset.
- Counters:
  - beat_cnt increments on each upstream handshake.
  - pkt_cnt increments on each upstream handshake with tlast=1.
  - Both hold at all-ones.
- clear:
  - Next edge: beat_cnt, pkt_cnt and err_flags go to 0.
  - A detection or handshake in the same cycle as clear is discarded, i.e. clear wins.
  - clear does not touch the datapath or seq_exp.
- Reset mid-packet: the buffer is flushed, in-flight beats are lost, seq_exp=0 and all counters are 0.

Decomposition:
- Shared package axis_chk_pkg:
  - Error-bit index constants ERR_VALID_DROP=0, ERR_PAYLOAD=1, ERR_SEQ=2, ERR_OVERLEN=3.
  - Default width constants.
- One sub-module, axis_skid_buffer: the parameterised two-entry datapath.
- The checker, counters and sequence tracker stay in the top.

Test Plan:
- 8-beat packet, beat n tdata = n<<56, tlast on beat 7, m_axis_tready always 1:
  - m_axis carries 8 identical beats one cycle later.
  - beat_cnt=8, pkt_cnt=1, err_flags=0.
- Same packet with m_axis_tready oscillating 6 cycles high / 2 cycles low:
  - output order and data intact, no bubbles beyond the stalls.
  - s_axis_tready drops only when the skid register is full.
  - err_flags=0.
- Hold tvalid=1 while s_axis_tready=0, then deassert tvalid:
  - err_flags[0]=1.
  - Repeat changing tdata instead: err_flags[1]=1.
- Packet whose second beat has top byte 0x05 instead of 0x01 -> err_flags[2]=1 with data still forwarded. A following correct 0..7 packet raises no new error (checked after clear).
- 300-beat packet without tlast with MAX_PKT_BEATS=256 -> err_flags[3] sets after beat 257.
- Pulse clear -> counters and errors read 0 next cycle. Assert aresetn=0 mid-packet -> m_axis_tvalid=0 and s_axis_tready=0 immediately; a fresh packet starting at 0 passes cleanly.
